vscale_hasti_sram_slave: RTL and testbench

AHB-lite (HASTI) responder that serves one vscale_core master port, imem or dmem, from an on-chip word-addressed memory array. It accepts pipelined address/data-phase transfers and inserts a configurable number of wait states. Byte lanes are written according to size and address. Illegal transfers get the two-cycle ERROR response. It is the memory-side counterpart of vscale_hasti_bridge, used in multicore test harnesses and as the default boot/data RAM.

---
 rtl/vscale_hasti_sram_slave.sv | 201 ++++++++++++++++++++
 tb/tb_vscale_hasti_sram_slave.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vscale_hasti_sram_slave.sv
// vscale_hasti_sram_slave: AHB-lite (HASTI) responder backed by a word-addressed
// on-chip RAM. Accepts pipelined address/data phases, inserts WAIT_STATES wait
// cycles per legal data phase, writes byte lanes by size/address and answers
// illegal transfers with the two-cycle ERROR response.
module vscale_hasti_sram_slave #(
    parameter int NWORDS      = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic        hmastlock,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp
);

    localparam int AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    localparam logic [1:0] S_READY = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_ERR1  = 2'd2;
    localparam logic [1:0] S_ERR2  = 2'd3;

    // Counter preload: S_WAIT is occupied WAIT_STATES cycles (load..0).
    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    // Illegal: oversize, out of range, or misaligned halfword/word.
    function automatic logic transfer_illegal(input logic [31:0] addr, input logic [2:0] size);
        logic bad;
        bad = 1'b0;
        if (size > 3'd2) begin
            bad = 1'b1;
        end else if (size == 3'd1 && addr[0] == 1'b1) begin
            bad = 1'b1;
        end else if (size == 3'd2 && addr[1:0] != 2'b00) begin
            bad = 1'b1;
        end else begin
            bad = 1'b0;
        end
        if ({2'b00, addr[31:2]} >= 32'(NWORDS)) begin
            bad = 1'b1;
        end else begin
            bad = bad;
        end
        return bad;
    endfunction

    // Byte-lane enables for a legal transfer of the given size and low address bits.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] mask;
        case (size)
            2'd0:    mask = 4'b0001 << lane;
            2'd1:    mask = lane[1] ? 4'b1100 : 4'b0011;
            2'd2:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    logic [1:0]    state_r;
    logic [1:0]    state_nx_s;
    logic [2:0]    wait_cnt_r;
    logic [2:0]    wait_cnt_nx_s;
    logic          pend_valid_r;
    logic          pend_write_r;
    logic [1:0]    pend_size_r;
    logic [1:0]    pend_byte_r;
    logic [AW-1:0] pend_word_r;
    logic [31:0]   mem [NWORDS];

    logic          hready_s;
    logic          hresp_s;
    logic          accept_s;
    logic          illegal_s;
    logic          commit_s;
    logic          read_done_s;
    logic [3:0]    wmask_s;
    logic          unused_s;

    // Bus controls that do not affect this responder.
    assign unused_s = ^{hburst, hmastlock, hprot, htrans[0]};

    assign accept_s    = hready_s & htrans[1];
    assign illegal_s   = transfer_illegal(haddr, hsize);
    assign commit_s    = (state_r == S_READY) & pend_valid_r & pend_write_r;
    assign read_done_s = (state_r == S_READY) & pend_valid_r & ~pend_write_r;
    assign wmask_s     = lane_mask(pend_size_r, pend_byte_r);

    assign hready = hready_s;
    assign hresp  = hresp_s;

    // Response signalling decoded from the state register.
    always_comb begin
        hready_s = 1'b1;
        hresp_s  = 1'b0;
        case (state_r)
            S_READY: begin hready_s = 1'b1; hresp_s = 1'b0; end
            S_WAIT:  begin hready_s = 1'b0; hresp_s = 1'b0; end
            S_ERR1:  begin hready_s = 1'b0; hresp_s = 1'b1; end
            S_ERR2:  begin hready_s = 1'b1; hresp_s = 1'b1; end
            default: begin hready_s = 1'b1; hresp_s = 1'b0; end
        endcase
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_nx_s    = state_r;
        wait_cnt_nx_s = wait_cnt_r;
        case (state_r)
            S_READY, S_ERR2: begin
                if (accept_s) begin
                    if (illegal_s) begin
                        state_nx_s    = S_ERR1;
                        wait_cnt_nx_s = 3'd0;
                    end else if (WAIT_STATES > 0) begin
                        state_nx_s    = S_WAIT;
                        wait_cnt_nx_s = WAIT_LOAD;
                    end else begin
                        state_nx_s    = S_READY;
                        wait_cnt_nx_s = 3'd0;
                    end
                end else begin
                    state_nx_s    = S_READY;
                    wait_cnt_nx_s = 3'd0;
                end
            end
            S_WAIT: begin
                if (wait_cnt_r == 3'd0) begin
                    state_nx_s    = S_READY;
                    wait_cnt_nx_s = 3'd0;
                end else begin
                    state_nx_s    = S_WAIT;
                    wait_cnt_nx_s = wait_cnt_r - 3'd1;
                end
            end
            S_ERR1: begin
                state_nx_s    = S_ERR2;
                wait_cnt_nx_s = 3'd0;
            end
            default: begin
                state_nx_s    = S_READY;
                wait_cnt_nx_s = 3'd0;
            end
        endcase
    end

    // State, wait counter and pending data-phase registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_READY;
            wait_cnt_r   <= 3'd0;
            pend_valid_r <= 1'b0;
            pend_write_r <= 1'b0;
            pend_size_r  <= 2'd0;
            pend_byte_r  <= 2'd0;
            pend_word_r  <= '0;
        end else begin
            state_r    <= state_nx_s;
            wait_cnt_r <= wait_cnt_nx_s;
            if (hready_s) begin
                // Only legal transfers leave a data phase that touches memory.
                pend_valid_r <= accept_s & ~illegal_s;
                if (accept_s) begin
                    pend_write_r <= hwrite;
                    pend_size_r  <= hsize[1:0];
                    pend_byte_r  <= haddr[1:0];
                    pend_word_r  <= haddr[AW+1:2];
                end
            end
        end
    end

    // Byte-lane write on the edge that ends a write data phase; dropped under reset.
    always_ff @(posedge clk) begin
        if (commit_s && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_s[i]) begin
                    mem[pend_word_r][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    // Read data only in the completing cycle of a legal read data phase.
    always_comb begin
        hrdata = 32'd0;
        if (read_done_s) begin
            hrdata = mem[pend_word_r];
        end else begin
            hrdata = 32'd0;
        end
    end

endmodule

// File: tb/tb_vscale_hasti_sram_slave.sv
// Self-checking bench: a zero-wait and a three-wait-state responder, driven by
// directed transfers; expected responses go through a scoreboard queue.
module tb_vscale_hasti_sram_slave;

    localparam int NW = 64;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] haddr_v  [2];
    logic        hwrite_v [2];
    logic [2:0]  hsize_v  [2];
    logic [1:0]  htrans_v [2];
    logic [31:0] hwdata_v [2];
    logic [31:0] hrdata_v [2];
    logic        hready_v [2];
    logic        hresp_v  [2];

    exp_t sb [$];
    int   n_pass   = 0;
    int   n_checks = 0;

    always #5 clk = ~clk;

    vscale_hasti_sram_slave #(.NWORDS(NW), .WAIT_STATES(0)) u0 (
        .clk(clk), .reset(reset), .haddr(haddr_v[0]), .hwrite(hwrite_v[0]),
        .hsize(hsize_v[0]), .hburst(3'd0), .hmastlock(1'b0), .hprot(4'd3),
        .htrans(htrans_v[0]), .hwdata(hwdata_v[0]), .hrdata(hrdata_v[0]),
        .hready(hready_v[0]), .hresp(hresp_v[0])
    );

    vscale_hasti_sram_slave #(.NWORDS(NW), .WAIT_STATES(3)) u3 (
        .clk(clk), .reset(reset), .haddr(haddr_v[1]), .hwrite(hwrite_v[1]),
        .hsize(hsize_v[1]), .hburst(3'd0), .hmastlock(1'b0), .hprot(4'd3),
        .htrans(htrans_v[1]), .hwdata(hwdata_v[1]), .hrdata(hrdata_v[1]),
        .hready(hready_v[1]), .hresp(hresp_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer (address phase, then data phase) on responder d.
    task automatic xfer(input int d, input string tag, input logic [31:0] a, input logic w,
                        input logic [2:0] sz, input logic [31:0] wd, input logic err,
                        input logic [31:0] rd);
        int   guard;
        int   waits;
        exp_t e;
        guard = 0;
        waits = 0;
        haddr_v[d]  = a;
        hwrite_v[d] = w;
        hsize_v[d]  = sz;
        htrans_v[d] = 2'd2;
        while (hready_v[d] !== 1'b1 && guard < 20) begin
            cyc();
            guard++;
        end
        if (guard >= 20) chk({tag, " accept timeout"}, 32'(guard), 32'd0);
        cyc();
        sb.push_back('{err, w ? 32'd0 : rd, err ? 1 : (d == 0 ? 0 : 3)});
        htrans_v[d] = 2'd0;
        hwdata_v[d] = wd;
        guard = 0;
        while (hready_v[d] !== 1'b1 && guard < 20) begin
            chk({tag, " stall hresp"}, 32'(hresp_v[d]), 32'(err));
            waits++;
            cyc();
            guard++;
        end
        e = sb.pop_front();
        chk({tag, " waits"}, 32'(waits), 32'(e.waits));
        chk({tag, " hresp"}, 32'(hresp_v[d]), 32'(e.err));
        chk({tag, " hrdata"}, hrdata_v[d], e.data);
        cyc();
        hwdata_v[d] = 32'd0;
        chk({tag, " idle hready"}, 32'(hready_v[d]), 32'd1);
        chk({tag, " idle hresp"}, 32'(hresp_v[d]), 32'd0);
    endtask

    initial begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            haddr_v[d]  = 32'd0;
            hwrite_v[d] = 1'b0;
            hsize_v[d]  = 3'd2;
            htrans_v[d] = 2'd0;
            hwdata_v[d] = 32'd0;
        end
        reset = 1'b1;
        cyc();
        cyc();
        for (int d = 0; d < 2; d++) begin
            chk("reset hready", 32'(hready_v[d]), 32'd1);
            chk("reset hresp", 32'(hresp_v[d]), 32'd0);
            chk("reset hrdata", hrdata_v[d], 32'd0);
        end
        reset = 1'b0;
        cyc();

        // Zero-wait back-to-back: write 0x10 then read 0x10 the next cycle.
        haddr_v[0] = 32'h10; hwrite_v[0] = 1'b1; hsize_v[0] = 3'd2; htrans_v[0] = 2'd2;
        cyc();
        sb.push_back('{1'b0, 32'd0, 0});
        hwdata_v[0] = 32'hDEADBEEF;
        hwrite_v[0] = 1'b0;
        e = sb.pop_front();
        chk("b2b wr hready", 32'(hready_v[0]), 32'd1);
        chk("b2b wr hrdata", hrdata_v[0], e.data);
        cyc();
        sb.push_back('{1'b0, 32'hDEADBEEF, 0});
        htrans_v[0] = 2'd0;
        hwdata_v[0] = 32'd0;
        e = sb.pop_front();
        chk("b2b rd hready", 32'(hready_v[0]), 32'd1);
        chk("b2b rd hresp", 32'(hresp_v[0]), 32'(e.err));
        chk("b2b rd hrdata", hrdata_v[0], e.data);
        cyc();

        // IDLE and BUSY with hwrite=1 must not touch memory.
        for (int t = 0; t < 2; t++) begin
            haddr_v[0] = 32'h10; hwrite_v[0] = 1'b1; hsize_v[0] = 3'd2;
            htrans_v[0] = 2'(t); hwdata_v[0] = 32'hFFFFFFFF;
            cyc();
            chk("idlebusy hready", 32'(hready_v[0]), 32'd1);
            chk("idlebusy hresp", 32'(hresp_v[0]), 32'd0);
            cyc();
        end
        htrans_v[0] = 2'd0;
        hwdata_v[0] = 32'd0;
        xfer(0, "idlebusy rd", 32'h10, 1'b0, 3'd2, 32'd0, 1'b0, 32'hDEADBEEF);

        // Byte and halfword lanes, junk on unselected lanes.
        xfer(0, "lane w", 32'h20, 1'b1, 3'd2, 32'h11223344, 1'b0, 32'd0);
        xfer(0, "lane b", 32'h21, 1'b1, 3'd0, 32'h5A5AAA5A, 1'b0, 32'd0);
        xfer(0, "lane h", 32'h22, 1'b1, 3'd1, 32'hBBCC7777, 1'b0, 32'd0);
        xfer(0, "lane rd", 32'h20, 1'b0, 3'd2, 32'd0, 1'b0, 32'hBBCCAA44);
        xfer(0, "byte3", 32'h23, 1'b1, 3'd0, 32'h99000000, 1'b0, 32'd0);
        xfer(0, "byte3 rd", 32'h20, 1'b0, 3'd2, 32'd0, 1'b0, 32'h99CCAA44);

        // Errors on the zero-wait responder.
        xfer(0, "e0 init", 32'h0, 1'b1, 3'd2, 32'hCAFEF00D, 1'b0, 32'd0);
        xfer(0, "e0 range", 32'(4 * NW), 1'b0, 3'd2, 32'd0, 1'b1, 32'd0);
        xfer(0, "e0 misalign", 32'h1, 1'b1, 3'd1, 32'hFFFFFFFF, 1'b1, 32'd0);
        xfer(0, "e0 wsize", 32'h0, 1'b1, 3'd3, 32'hFFFFFFFF, 1'b1, 32'd0);
        xfer(0, "e0 after", 32'h0, 1'b0, 3'd2, 32'd0, 1'b0, 32'hCAFEF00D);
        xfer(0, "e0 last", 32'(4 * NW - 4), 1'b1, 3'd2, 32'h0F0F0F0F, 1'b0, 32'd0);
        xfer(0, "e0 last rd", 32'(4 * NW - 4), 1'b0, 3'd2, 32'd0, 1'b0, 32'h0F0F0F0F);

        // Three wait states.
        xfer(1, "w3 wr0", 32'h0, 1'b1, 3'd2, 32'h0BADF00D, 1'b0, 32'd0);
        xfer(1, "w3 rd0", 32'h0, 1'b0, 3'd2, 32'd0, 1'b0, 32'h0BADF00D);
        xfer(1, "w3 wr4", 32'h4, 1'b1, 3'd2, 32'h13579BDF, 1'b0, 32'd0);
        xfer(1, "w3 rd4", 32'h4, 1'b0, 3'd2, 32'd0, 1'b0, 32'h13579BDF);
        xfer(1, "w3 err", 32'(4 * NW), 1'b0, 3'd2, 32'd0, 1'b1, 32'd0);
        xfer(1, "w3 herr", 32'h5, 1'b1, 3'd1, 32'hFFFFFFFF, 1'b1, 32'd0);
        xfer(1, "w3 after", 32'h4, 1'b0, 3'd2, 32'd0, 1'b0, 32'h13579BDF);

        // Reset while a write to 0x30 waits: the write is dropped.
        xfer(1, "rst init", 32'h30, 1'b1, 3'd2, 32'h0, 1'b0, 32'd0);
        haddr_v[1] = 32'h30; hwrite_v[1] = 1'b1; hsize_v[1] = 3'd2; htrans_v[1] = 2'd2;
        cyc();
        htrans_v[1] = 2'd0;
        hwdata_v[1] = 32'h12345678;
        chk("rst in wait", 32'(hready_v[1]), 32'd0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rst hready", 32'(hready_v[1]), 32'd1);
        chk("rst hresp", 32'(hresp_v[1]), 32'd0);
        cyc();
        hwdata_v[1] = 32'd0;
        xfer(1, "rst rd", 32'h30, 1'b0, 3'd2, 32'd0, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
